serial_subtractor: RTL

- Bit-serial multi-bit subtractor built around a one-bit full-subtractor cell.
- Computes diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- Latches operands on a start pulse, shifts them through the cell, and feeds the cell's borrow output back through a flip-flop.
- Collects the difference in a shift register and reports completion with a done pulse.

---
 rtl/serial_subtractor.sv | 89 ++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow loop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    // One-bit full-subtractor cell working on the current LSBs.
    logic d;
    logic nb;

    assign d  = sa[0] ^ sb[0] ^ br;
    assign nb = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);

    // NOTE: every register here is assigned with <= so all updates use the
    // pre-edge values, which is what lets the borrow loop and shifts line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res <= {d, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= nb;
                    cnt <= cnt + CW'(1);
                    // Last bit: publish the completed word and its borrow.
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= nb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
